ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite slave that consumes the address/control and write-data outputs of the team's `master` block and returns read data, ready and response. It is the downstream stage on the bus. It decodes a 64 KB window into a word-organised SRAM and honours byte, halfword and word transfers. Each data phase is stretched by a configurable number of wait states. Illegal transfers get the standard two-cycle ERROR response.

## Interface
Parameters:
- `ADDR_W`, default 8: log2 of memory depth in 32-bit words (1..13).
- `WAIT_STATES`, default 1: wait cycles inserted per OKAY data phase (0..15).

Ports:
- `Hclk`  in  1: bus clock. Single clock domain.
- `Hrst`  in  1: reset, synchronous and active-high.
- `HSEL`  in  1: slave select from the address decoder.
- `HADDR`  in  32: transfer address.
- `HTRANS`  in  2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `HWRITE`  in  1: 1 = write.
- `HSIZE`  in  3: 0 = byte, 1 = half, 2 = word; larger values are illegal.
- `HBURST`  in  3: accepted and ignored, since every beat is decoded independently.
- `HWDATA`  in  32: write data, valid throughout the data phase.
- `HREADY`  in  1: global bus ready. An address phase is taken only when this is 1.
- `HRDATA`  out  32: read data.
- `HREADYOUT`  out  1: slave ready.
- `HRESP`  out  1: 0 = OKAY, 1 = ERROR.

## Operation
- Accept condition: `HSEL & HREADY & HTRANS[1]` at a rising edge. On accept, latch `HADDR`, `HWRITE` and `HSIZE`, and start a data phase.
- IDLE or BUSY with `HSEL`=1 gives a zero-wait OKAY (`HREADYOUT`=1, `HRESP`=0) and no access.
- Error check, performed at accept:
  - `HSIZE`>2, or
  - misaligned address (half with `HADDR[0]`=1; word with `HADDR[1:0]`≠0), or
  - `HADDR[15:ADDR_W+2]` not all zero (outside the memory).
- State machine:
  - ST_IDLE: `HREADYOUT`=1, `HRESP`=0. On an accept with an error, go to ST_ERR1. On a valid accept, go to ST_WAIT if `WAIT_STATES`>0, else ST_DATA.
  - ST_WAIT: `HREADYOUT`=0. A counter loads `WAIT_STATES`-1 and decrements; at 0, go to ST_DATA.
  - ST_DATA: `HREADYOUT`=1, `HRESP`=0; the transfer completes this cycle. A new accept in the same cycle re-enters ST_ERR1, ST_WAIT or ST_DATA as above. With no accept, go to ST_IDLE.
  - ST_ERR1: `HREADYOUT`=0, `HRESP`=1. Go to ST_ERR2.
  - ST_ERR2: `HREADYOUT`=1, `HRESP`=1. A new accept in this cycle is handled as in ST_DATA; otherwise go to ST_IDLE.
- Writes commit at the rising edge that ends ST_DATA, using `HWDATA` sampled at that edge.
  - Byte enables are little-endian. Byte: lane `HADDR[1:0]`. Half: lanes {`HADDR[1]`*2+1, `HADDR[1]`*2}. Word: all lanes.
  - ERROR transfers never write.
- Reads: `HRDATA` is the full 32-bit word at the latched word index (`HADDR[ADDR_W+1:2]`) while in ST_DATA with a read latched; it is 0 in every other state. Byte and half reads return the whole word.

## Timing
- Reset values: state ST_IDLE, `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0, wait counter 0. Memory contents are not reset.
- OKAY data phase length is `WAIT_STATES`+1 cycles after the address phase. With `WAIT_STATES`=0, read data appears in the cycle immediately after the address phase.
- ERROR data phase is always 2 cycles, regardless of `WAIT_STATES`.
- Back-to-back transfers: a write followed by a read of the same word returns the new data. The write commits on the same edge that latches the read address.
- `HREADY`=0 while this slave is idle (another slave is stalling): no accept, and all outputs hold their ST_IDLE values.
- `Hrst` asserted mid data phase: the transfer is abandoned, a pending write is not committed, and outputs take reset values on the next edge.
- `HSEL` deasserted during a data phase has no effect; the phase runs to completion.

## Structure
- Shared package `ahb_pkg` holds:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ),
  - HSIZE codes (BYTE, HALF, WORD),
  - HRESP codes (OKAY, ERROR),
  - the slave state enum (ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2).
  
  These codes are reused by `master` and the decoder.
- One sub-module, `ahb_sram_array`: 2^`ADDR_W` x 32 storage, combinational read port, synchronous write with a 4-bit byte enable.

## Test plan
- Reset, then idle with `HSEL`=1 and `HTRANS`=IDLE → `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0 throughout.
- `WAIT_STATES`=1: word write 0x0000002A to 0x48, then word read from 0x48 → `HREADYOUT` low for 1 cycle in each data phase, then `HRDATA`=0x0000002A.
- Word write 0x00000000 to 0x4C, byte write 0x8E (`HWDATA`=0x00008E00) to 0x4D, then read 0x4C → 0x00008E00.
- Word write to 0x4A (misaligned) → `HREADYOUT`/`HRESP` sequence 0/1 then 1/1; a following read of 0x48 still returns 0x0000002A.
- `WAIT_STATES`=0: pipelined NONSEQ write to 0x50 (0xDEADBEEF), then a read of 0x50 in the next address phase → no wait cycles, `HRDATA`=0xDEADBEEF.
- Assert `Hrst` during ST_WAIT of a write of 0x11111111 to 0x48 → outputs reset next edge; a later read of 0x48 returns 0x0000002A.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite bus codes and the SRAM slave state encoding.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

  // Little-endian byte lanes touched by a transfer of the given size.
  function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << lane;
      SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM: combinational read, byte-enabled synchronous write.
module ahb_sram_array #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Write only the enabled byte lanes; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a word SRAM with configurable wait states
// and the two-cycle ERROR response for illegal transfers.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        Hclk,
  input  logic        Hrst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state_t      state, next;
  logic [3:0]        cnt;
  logic [ADDR_W+1:0] addr_q;
  logic              wr_q;
  logic [2:0]        size_q;
  logic [15:0]       hi_bits;
  logic              accept, take, req_err, mem_we;
  logic [31:0]       mem_rdata;
  logic              unused_bits;

  // Every beat is decoded on its own, so burst type and HTRANS[0] are ignored.
  assign unused_bits = ^{HBURST, HADDR[31:16], HTRANS[0]};

  assign accept  = HSEL & HREADY & HTRANS[1];
  // Address phases are only sampled in states where this slave drives ready high.
  assign take    = accept && (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);
  assign hi_bits = HADDR[15:0] >> (ADDR_W + 2);
  assign req_err = (HSIZE > SIZE_WORD)
                || (HSIZE == SIZE_HALF && HADDR[0])
                || (HSIZE == SIZE_WORD && HADDR[1:0] != 2'b00)
                || (|hi_bits);

  // State register.
  always_ff @(posedge Hclk) begin
    if (Hrst) state <= ST_IDLE;
    else      state <= next;
  end

  // Address-phase capture and wait-state countdown.
  always_ff @(posedge Hclk) begin
    if (Hrst) begin
      cnt    <= '0;
      addr_q <= '0;
      wr_q   <= 1'b0;
      size_q <= '0;
    end else begin
      if (take) begin
        addr_q <= HADDR[ADDR_W+1:0];
        wr_q   <= HWRITE;
        size_q <= HSIZE;
      end
      if (take && !req_err && WAIT_STATES > 0) cnt <= WAIT_LOAD;
      else if (state == ST_WAIT && cnt != 0)   cnt <= cnt - 4'd1;
    end
  end

  // Next-state decode.
  always_comb begin
    next = state;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!take)                 next = ST_IDLE;
        else if (req_err)          next = ST_ERR1;
        else if (WAIT_STATES > 0)  next = ST_WAIT;
        else                       next = ST_DATA;
      end
      ST_WAIT: if (cnt == 0) next = ST_DATA;
      ST_ERR1: next = ST_ERR2;
      default: next = ST_IDLE;
    endcase
  end

  // Bus outputs from the current state.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = RESP_OKAY;
    HRDATA    = '0;
    case (state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_DATA: if (!wr_q) HRDATA = mem_rdata;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = RESP_ERROR;
      end
      ST_ERR2: HRESP = RESP_ERROR;
      default: ;
    endcase
  end

  // A reset on the closing edge abandons the write.
  assign mem_we = (state == ST_DATA) && wr_q && !Hrst;

  ahb_sram_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (Hclk),
    .we    (mem_we),
    .be    (byte_enables(size_q, addr_q[1:0])),
    .addr  (addr_q[ADDR_W+1:2]),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave with one and zero wait states.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          waits;
  } exp_t;

  logic        Hclk = 1'b0;
  logic        Hrst = 1'b1;
  logic        HSEL = 1'b1;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = TRANS_IDLE;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = SIZE_WORD;
  logic [2:0]  HBURST = 3'd0;
  logic [31:0] HWDATA = '0;
  logic        use0 = 1'b0;
  logic        HREADY;
  logic [31:0] rd1, rd0;
  logic        rdy1, rdy0, rsp1, rsp0;
  logic        sel1, sel0;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  always #5 Hclk = ~Hclk;

  assign sel1   = HSEL & ~use0;
  assign sel0   = HSEL & use0;
  assign HREADY = use0 ? rdy0 : rdy1;

  ahb_sram_slave #(.ADDR_W(8), .WAIT_STATES(1)) u_ws1 (
    .Hclk(Hclk), .Hrst(Hrst), .HSEL(sel1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(rd1), .HREADYOUT(rdy1), .HRESP(rsp1)
  );

  ahb_sram_slave #(.ADDR_W(8), .WAIT_STATES(0)) u_ws0 (
    .Hclk(Hclk), .Hrst(Hrst), .HSEL(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(rsp0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold the current address phase until it is accepted (bounded).
  task automatic wait_ready();
    logic r;
    for (int i = 0; i < 40; i++) begin
      @(negedge Hclk);
      r = HREADY;
      @(posedge Hclk);
      #1;
      if (r) return;
    end
    chk("ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input bit exp_err, input int exp_w);
    exp_q.push_back('{rdata: exp_rd, err: exp_err, waits: exp_w});
    HSEL = 1'b1; HTRANS = TRANS_NONSEQ; HADDR = a; HWRITE = wr; HSIZE = sz;
    wait_ready();
    HWDATA = wd;
  endtask

  task automatic go_idle();
    HTRANS = TRANS_IDLE;
    wait_ready();
    repeat (2) @(posedge Hclk);
    #1;
  endtask

  // Monitor: counts stalled cycles of each data phase and checks the completion beat.
  initial begin
    bit   active = 0;
    bit   wait_err = 0;
    int   waits = 0;
    exp_t e;
    logic rdy, rsp;
    logic [31:0] rd;
    forever begin
      @(negedge Hclk);
      if (!mon_en) begin
        active = 0; waits = 0; wait_err = 0;
        continue;
      end
      rdy = use0 ? rdy0 : rdy1;
      rsp = use0 ? rsp0 : rsp1;
      rd  = use0 ? rd0  : rd1;
      chk("other_idle", {rd0 | rd1} & (use0 ? rd1 : rd0) | 32'(use0 ? {~rdy1, rsp1} : {~rdy0, rsp0}), 32'd0);
      if (active) begin
        if (!rdy) begin
          waits++;
          if (rsp) wait_err = 1;
        end else begin
          if (exp_q.size() == 0) begin
            chk("unexpected_phase", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("wait_cycles", 32'(waits), 32'(e.waits));
            chk("wait_resp", 32'(wait_err), 32'(e.err && e.waits > 0));
            chk("hresp", 32'(rsp), 32'(e.err));
            chk("hrdata", rd, e.rdata);
          end
          active = 0; waits = 0; wait_err = 0;
        end
      end else begin
        chk("idle_out", {rd[31:2] | rd[1:0], 30'd0} | 32'({~rdy, rsp}) | rd, 32'd0);
      end
      if (rdy && HSEL && HTRANS[1]) active = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge Hclk);
    #1;
    Hrst = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge Hclk);
    #1;

    // One wait state
    xfer(1, 32'h48, SIZE_WORD, 32'h0000002A, 32'h0, 0, 1);
    xfer(0, 32'h48, SIZE_WORD, 32'h0,        32'h0000002A, 0, 1);
    xfer(1, 32'h4C, SIZE_WORD, 32'h00000000, 32'h0, 0, 1);
    xfer(1, 32'h4D, SIZE_BYTE, 32'h00008E00, 32'h0, 0, 1);
    xfer(0, 32'h4C, SIZE_WORD, 32'h0,        32'h00008E00, 0, 1);
    xfer(1, 32'h4A, SIZE_WORD, 32'hFFFFFFFF, 32'h0, 1, 1);
    xfer(0, 32'h48, SIZE_WORD, 32'h0,        32'h0000002A, 0, 1);
    xfer(1, 32'h4E, SIZE_HALF, 32'hABCD0000, 32'h0, 0, 1);
    xfer(0, 32'h4C, SIZE_BYTE, 32'h0,        32'hABCD8E00, 0, 1);
    xfer(1, 32'h49, SIZE_HALF, 32'h55555555, 32'h0, 1, 1);
    xfer(0, 32'h48, 3'd3,      32'h0,        32'h0, 1, 1);
    xfer(1, 32'h400, SIZE_WORD, 32'h77777777, 32'h0, 1, 1);
    xfer(1, 32'h3FC, SIZE_WORD, 32'hCAFEF00D, 32'h0, 0, 1);
    xfer(0, 32'h3FC, SIZE_WORD, 32'h0,        32'hCAFEF00D, 0, 1);
    xfer(0, 32'h4C, SIZE_WORD, 32'h0,        32'hABCD8E00, 0, 1);
    go_idle();

    // Zero wait states, pipelined
    use0 = 1'b1;
    repeat (2) @(posedge Hclk);
    #1;
    xfer(1, 32'h50, SIZE_WORD, 32'hDEADBEEF, 32'h0, 0, 0);
    xfer(0, 32'h50, SIZE_WORD, 32'h0,        32'hDEADBEEF, 0, 0);
    xfer(1, 32'h51, SIZE_BYTE, 32'h00001200, 32'h0, 0, 0);
    xfer(0, 32'h50, SIZE_WORD, 32'h0,        32'hDEAD12EF, 0, 0);
    go_idle();
    use0 = 1'b0;
    repeat (2) @(posedge Hclk);
    #1;

    // Reset during the wait cycle of a write
    mon_en = 1'b0;
    HTRANS = TRANS_NONSEQ; HADDR = 32'h48; HWRITE = 1'b1; HSIZE = SIZE_WORD;
    wait_ready();
    HTRANS = TRANS_IDLE; HWDATA = 32'h11111111; Hrst = 1'b1;
    @(negedge Hclk);
    chk("rst_wait_ready", 32'(rdy1), 32'd0);
    @(posedge Hclk);
    #1;
    Hrst = 1'b0;
    @(negedge Hclk);
    chk("rst_out_ready", 32'(rdy1), 32'd1);
    chk("rst_out_resp",  32'(rsp1), 32'd0);
    chk("rst_out_rdata", rd1, 32'd0);

    // Reset on the edge that would commit a write
    @(posedge Hclk);
    #1;
    HTRANS = TRANS_NONSEQ; HADDR = 32'h48; HWRITE = 1'b1; HSIZE = SIZE_WORD;
    wait_ready();
    HTRANS = TRANS_IDLE; HWDATA = 32'h22222222;
    @(posedge Hclk);
    #1;
    Hrst = 1'b1;
    @(negedge Hclk);
    chk("rst_data_ready", 32'(rdy1), 32'd1);
    @(posedge Hclk);
    #1;
    Hrst = 1'b0;
    @(negedge Hclk);
    chk("rst2_out_ready", 32'(rdy1), 32'd1);
    @(posedge Hclk);
    #1;
    mon_en = 1'b1;
    xfer(0, 32'h48, SIZE_WORD, 32'h0, 32'h0000002A, 0, 1);
    go_idle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
